bcd2bin: RTL and testbench
==========================

# bcd2bin

Sequential reverse double-dabble converter: accepts a 4-digit packed BCD value (0–9999) and produces the equivalent 14-bit unsigned binary value. It is the inverse companion of the binary-to-BCD converter and sits between BCD-entry sources (keypad/display front ends) and binary datapath logic. It uses the same single-pulse `en` / `rdy` handshake and runs one shift or adjust step per clock.

## Interface
- No parameters. Widths are fixed: 4 BCD digits in, 14 bits out.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  start request; sampled only in IDLE.
- `bcd_d_in`  input  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- `bin_d_out`  output  14  binary result; holds the last completed conversion.
- `rdy`  output  1  one-cycle pulse: `bin_d_out`/`err` updated this cycle.
- `busy`  output  1  high from the capture edge until return to IDLE.
- `err`  output  1  invalid-digit flag, updated together with `rdy`.

## Operation
- Working registers: 16-bit `bcd_sr`, 14-bit `bin_sr`, 4-bit `sh_cnt`.
- States: IDLE, SHIFT, ADJ, DONE. Encoding is free; unused codes go to IDLE.
- IDLE, `en`=1: load `bcd_sr`<=`bcd_d_in`, clear `bin_sr`, clear `sh_cnt`, set `busy`<=1, go to SHIFT. With `en`=0, stay in IDLE.
- SHIFT: shift {`bcd_sr`,`bin_sr`} right by 1, so `bcd_sr[0]` enters `bin_sr[13]` and 0 enters `bcd_sr[15]`. Increment `sh_cnt`.
  - If `sh_cnt`==13 before the increment, go to DONE.
  - Otherwise go to ADJ.
- ADJ: in one cycle, independently for each of the 4 nibbles of `bcd_sr`, if nibble ≥ 8 then nibble <= nibble − 3 (4-bit, no borrow between nibbles). Go to SHIFT.
- DONE: `bin_d_out`<=`bin_sr`, `rdy`<=1, `busy`<=0, go to IDLE.
- IDLE clears `rdy` to 0 on every cycle it is not entered from DONE, so `rdy` is exactly one cycle wide.
- `en` in SHIFT, ADJ or DONE is ignored. `bcd_d_in` is only sampled at the capture edge.
- Reset (async, any state, including mid-conversion): state IDLE, `bin_d_out`=0, `rdy`=0, `busy`=0, `err`=0, working registers 0. No partial result is ever presented.

## Timing
- Capture edge E0, then 14 SHIFT and 13 ADJ cycles alternating (E1..E27).
- DONE executes at E28. `rdy`=1 and the result is valid in the cycle after E28: 28 cycles of latency from the `en`-sampled edge.
- `busy` is high after E0 through E28.
- The cycle with `rdy`=1 is an IDLE cycle, so `en` asserted there is accepted. Back-to-back throughput is one conversion per 29 cycles.
- `bin_d_out` and `err` are stable between `rdy` pulses.

## Configuration
- `BCD2BIN_CHECK_EN` defined:
  - At the capture edge, if any digit of `bcd_d_in` is > 9, the block goes directly from IDLE to DONE and skips SHIFT/ADJ.
  - DONE then drives `bin_d_out`=0, `err`=1, `rdy`=1. `rdy` appears 1 cycle after capture.
  - For a valid input, `err`=0 with the result.
- Not defined:
  - No check is made. `err` is tied 0.
  - Invalid digits run the normal 28-cycle path and `bin_d_out` is unspecified.
  - Handshake timing is unchanged.

## Test plan
- Reset, then `bcd_d_in`=16'h0000, `en` pulse -> `rdy` at +28 cycles, `bin_d_out`=0, `err`=0, `busy` high for 28 cycles.
- 16'h9999 -> `bin_d_out`=14'd9999 (0x270F). 16'h4095 -> 0x0FFF. 16'h0010 -> 10. All with 28-cycle latency.
- Start 16'h1234, hold `en`=1 with `bcd_d_in` changed to 16'h5678 during the conversion -> `bin_d_out`=1234. `en` during the `rdy` cycle starts the 5678 conversion, which completes 29 cycles after the first `rdy`.
- Start 16'h8888, assert `rst_n`=0 at cycle 10 -> outputs 0 immediately, no `rdy`. After release, 16'h0007 converts to 7 normally.
- With `BCD2BIN_CHECK_EN`: 16'h12A4 -> `rdy` 1 cycle after capture, `err`=1, `bin_d_out`=0. A following 16'h0042 -> 42 with `err`=0.
- Exhaustive sweep 0..9999 back-to-back -> every result matches the decimal value. `rdy` never lasts more than 1 cycle.

Source files
------------

// File: rtl/bcd2bin.sv
// bcd2bin -- sequential reverse double-dabble converter.
//
// Converts a 4-digit packed BCD value (0..9999) into a 14-bit unsigned binary
// value. The converter runs one shift or one adjust step per clock. It takes
// 14 shifts and 13 adjusts, so a result is ready 28 cycles after capture.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   start request, sampled only while idle
//   bcd_d_in   in  16   packed BCD {thousands, hundreds, tens, units}
//   bin_d_out  out 14   last completed conversion result
//   rdy        out  1   one-cycle pulse: bin_d_out / err updated
//   busy       out  1   high from capture until the return to idle
//   err        out  1   invalid-digit flag, updated with rdy
//
// Configuration macro: BCD2BIN_CHECK_EN
//   defined   : a digit > 9 at capture skips the conversion. It then
//               reports bin_d_out = 0 and err = 1 one cycle later.
//   undefined : no digit check is made and err is tied low.

module bcd2bin (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] bcd_d_in,
  output logic [13:0] bin_d_out,
  output logic        rdy,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ADJ   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Last shift happens when the counter already shows 13 shifts done.
  localparam logic [3:0] LAST_SHIFT = 4'd13;

  state_e      state_q, state_d;
  logic [15:0] bcd_sr_q, bcd_sr_d;
  logic [13:0] bin_sr_q, bin_sr_d;
  logic [3:0]  sh_cnt_q, sh_cnt_d;
  logic [13:0] bin_d_out_q, bin_d_out_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  // Undo the doubling for each digit. After a right shift, a digit >= 8
  // received a 1 from the digit above it. That 1 is worth 10/2 = 5, but it
  // landed as a bit worth 8, so the digit is corrected by subtracting 3.
  // Each nibble is corrected on its own; there is no borrow between nibbles.
  function automatic logic [15:0] adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4+3]) r[i*4 +: 4] = v[i*4 +: 4] - 4'd3;
    end
    return r;
  endfunction

`ifdef BCD2BIN_CHECK_EN
  logic err_q, err_d;
  logic err_pend_q, err_pend_d;

  function automatic logic digits_valid(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction
`endif

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can infer a latch.
    state_d     = state_q;
    bcd_sr_d    = bcd_sr_q;
    bin_sr_d    = bin_sr_q;
    sh_cnt_d    = sh_cnt_q;
    bin_d_out_d = bin_d_out_q;
    rdy_d       = 1'b0;          // rdy is high only in the cycle after DONE
    busy_d      = busy_q;
`ifdef BCD2BIN_CHECK_EN
    err_d       = err_q;
    err_pend_d  = err_pend_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          bcd_sr_d = bcd_d_in;
          bin_sr_d = '0;
          sh_cnt_d = '0;
          busy_d   = 1'b1;
          state_d  = S_SHIFT;
`ifdef BCD2BIN_CHECK_EN
          err_pend_d = !digits_valid(bcd_d_in);
          // bin_sr is already cleared, so DONE presents 0 for a rejected input.
          if (!digits_valid(bcd_d_in)) state_d = S_DONE;
`endif
        end
      end

      S_SHIFT: begin
        {bcd_sr_d, bin_sr_d} = {1'b0, bcd_sr_q, bin_sr_q[13:1]};
        sh_cnt_d = sh_cnt_q + 4'd1;
        state_d  = (sh_cnt_q == LAST_SHIFT) ? S_DONE : S_ADJ;
      end

      S_ADJ: begin
        bcd_sr_d = adjust(bcd_sr_q);
        state_d  = S_SHIFT;
      end

      S_DONE: begin
        bin_d_out_d = bin_sr_q;
        rdy_d       = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
`ifdef BCD2BIN_CHECK_EN
        err_d       = err_pend_q;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bcd_sr_q    <= '0;
      bin_sr_q    <= '0;
      sh_cnt_q    <= '0;
      bin_d_out_q <= '0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_sr_q    <= bcd_sr_d;
      bin_sr_q    <= bin_sr_d;
      sh_cnt_q    <= sh_cnt_d;
      bin_d_out_q <= bin_d_out_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
    end
  end

`ifdef BCD2BIN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bin_d_out = bin_d_out_q;
  assign rdy       = rdy_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin -- self-checking bench for bcd2bin.
// The bench runs a table of directed vectors and several hand-written
// sequences: back-to-back capture with en held high, a reset in the middle
// of a conversion, and a strided back-to-back sweep of 0..9999.
// Inputs are driven and outputs are sampled on the falling clock edge.

module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] bcd_d_in = '0;
  logic [13:0] bin_d_out;
  logic        rdy;
  logic        busy;
  logic        err;

  bcd2bin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bcd_d_in  (bcd_d_in),
    .bin_d_out (bin_d_out),
    .rdy       (rdy),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] bcd;
    int          exp_bin;
    int          exp_lat;
    int          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Called at the falling edge just after the capture edge. Returns the
  // number of falling edges until rdy is seen, and how many of them had busy
  // high. If the budget expires, cycles returns the budget value.
  task automatic wait_rdy(input int budget, output int cycles, output int busy_cnt);
    cycles = 0;
    busy_cnt = 0;
    while (cycles < budget) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
      if (rdy) break;
    end
  endtask

  task automatic start(input logic [15:0] v);
    @(negedge clk);
    bcd_d_in = v;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    int   c, b, rdy_seen, gap_bad;
    int   vals[$];

    vecs.push_back('{16'h0000,    0, 28, 0});
    vecs.push_back('{16'h9999, 9999, 28, 0});
    vecs.push_back('{16'h4095, 4095, 28, 0});
    vecs.push_back('{16'h0010,   10, 28, 0});
    vecs.push_back('{16'h0001,    1, 28, 0});
    vecs.push_back('{16'h8192, 8192, 28, 0});
    vecs.push_back('{16'h0800,  800, 28, 0});
    vecs.push_back('{16'h0099,   99, 28, 0});
    vecs.push_back('{16'h6553, 6553, 28, 0});
`ifdef BCD2BIN_CHECK_EN
    vecs.push_back('{16'h12A4,    0,  1, 1});
    vecs.push_back('{16'h0042,   42, 28, 0});
    vecs.push_back('{16'h000F,    0,  1, 1});
    vecs.push_back('{16'h0007,    7, 28, 0});
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_bin",  32'(bin_d_out), 0);
    check("reset_rdy",  32'(rdy), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_err",  32'(err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_rdy",  32'(rdy), 0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      start(vecs[i].bcd);
      wait_rdy(60, c, b);
      check($sformatf("bin[%h]",  vecs[i].bcd), 32'(bin_d_out), vecs[i].exp_bin);
      check($sformatf("err[%h]",  vecs[i].bcd), 32'(err), vecs[i].exp_err);
      check($sformatf("lat[%h]",  vecs[i].bcd), c, vecs[i].exp_lat);
      check($sformatf("busy[%h]", vecs[i].bcd), b, vecs[i].exp_lat);
      @(negedge clk);
      check($sformatf("rdy_width[%h]", vecs[i].bcd), 32'(rdy), 0);
    end

    // Back-to-back: en is held high and the input changes mid-conversion.
    @(negedge clk);
    bcd_d_in = 16'h1234;
    en = 1'b1;
    @(negedge clk);
    bcd_d_in = 16'h5678;
    wait_rdy(60, c, b);
    check("b2b_first_bin", 32'(bin_d_out), 1234);
    check("b2b_first_lat", c, 28);
    repeat (15) @(negedge clk);
    check("b2b_hold_bin",  32'(bin_d_out), 1234);
    check("b2b_busy_mid",  32'(busy), 1);
    wait_rdy(60, c, b);
    en = 1'b0;
    check("b2b_second_bin", 32'(bin_d_out), 5678);
    check("b2b_second_gap", c + 15, 29);
    @(negedge clk);
    check("b2b_rdy_width", 32'(rdy), 0);

    // Reset in the middle of a conversion.
    start(16'h8888);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_bin",  32'(bin_d_out), 0);
    check("midrst_rdy",  32'(rdy), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy) rdy_seen++;
    end
    check("midrst_no_rdy", rdy_seen, 0);
    start(16'h0007);
    wait_rdy(60, c, b);
    check("post_rst_bin", 32'(bin_d_out), 7);
    check("post_rst_lat", c, 28);

    // Strided back-to-back sweep over 0..9999.
    for (int v = 0; v <= 9999; v += 97) vals.push_back(v);
    vals.push_back(9999);
    gap_bad = 0;
    @(negedge clk);
    bcd_d_in = to_bcd(vals[0]);
    en = 1'b1;
    @(negedge clk);
    foreach (vals[i]) begin
      wait_rdy(60, c, b);
      if (c != ((i == 0) ? 28 : 29)) gap_bad++;
      check($sformatf("sweep[%0d]", vals[i]), 32'(bin_d_out), vals[i]);
      if (i == vals.size() - 1) en = 1'b0;
      else bcd_d_in = to_bcd(vals[i+1]);
    end
    @(negedge clk);
    check("sweep_rdy_width", 32'(rdy), 0);
    check("sweep_gaps", gap_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
